// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: Wishbone read master feeding a DEPTH-entry {pc, inst} queue.
// Optional IFU_BYPASS_EN: an empty queue forwards ack data to the ID stage in the ack cycle.
module ifu_prefetch #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ibus_cyc_o,
    output logic                ibus_stb_o,
    output logic                ibus_we_o,
    output logic [DATA_W/8-1:0] ibus_sel_o,
    output logic [ADDR_W-1:0]   ibus_adr_o,
    input  logic                ibus_ack_i,
    input  logic [DATA_W-1:0]   ibus_dat_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   pc_o,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t            state;
    logic              cyc_q;
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              accept;
    logic              push;
    logic              pop;
    logic              q_valid;

    assign q_valid = (count != '0);
    // Only an ack of our own REQ transfer carries a wanted instruction; DRAIN acks are stale.
    assign accept  = (state == REQ) && ibus_ack_i && !redirect_i;
    assign pop     = q_valid && inst_ready_i && !redirect_i;

`ifdef IFU_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit   = accept && (count == '0);
    assign push         = accept && !(bypass_hit && inst_ready_i);
    assign inst_valid_o = q_valid || bypass_hit;
    assign inst_o       = bypass_hit ? ibus_dat_i : inst_mem[rd_ptr];
    assign pc_o         = bypass_hit ? fetch_pc   : pc_mem[rd_ptr];
`else
    assign push         = accept;
    assign inst_valid_o = q_valid;
    assign inst_o       = inst_mem[rd_ptr];
    assign pc_o         = pc_mem[rd_ptr];
`endif

    assign count_next      = count + CNT_W'(push) - CNT_W'(pop);
    assign redirect_target = redirect_i ? redirect_pc_i : fetch_pc;

    assign ibus_cyc_o = cyc_q;
    assign ibus_stb_o = cyc_q;
    assign ibus_we_o  = 1'b0;
    assign ibus_sel_o = '1;
    assign ibus_adr_o = adr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage is cleared on reset so the head outputs read zero before the first fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= ibus_dat_i;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cyc_q    <= 1'b0;
            adr_q    <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_pc_i;
                    end else if (count < FULL) begin
                        state <= REQ;
                        cyc_q <= 1'b1;
                        adr_q <= fetch_pc;
                    end
                end
                REQ: begin
                    if (ibus_ack_i && redirect_i) begin
                        fetch_pc <= redirect_pc_i;
                        adr_q    <= redirect_pc_i;
                    end else if (ibus_ack_i) begin
                        fetch_pc <= fetch_pc + ADDR_W'(4);
                        if (count_next < FULL) begin
                            adr_q <= fetch_pc + ADDR_W'(4);
                        end else begin
                            state <= IDLE;
                            cyc_q <= 1'b0;
                        end
                    end else if (redirect_i) begin
                        // The bus transfer cannot be aborted, so wait out its ack in DRAIN.
                        fetch_pc <= redirect_pc_i;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    fetch_pc <= redirect_target;
                    if (ibus_ack_i) begin
                        if (redirect_i || count_next < FULL) begin
                            state <= REQ;
                            adr_q <= redirect_target;
                        end else begin
                            state <= IDLE;
                            cyc_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised instruction-fetch unit that replaces the single-cycle instruction-bus assumption of the current core.
- Drives a classic Wishbone read master that tolerates arbitrary wait states.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry queue and hands them to the IF/ID register with a valid/ready handshake.
- Supports a pipeline redirect (branch/exception) that flushes the queue and restarts fetch.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ibus_cyc_o  out  1  Wishbone cycle.
- ibus_stb_o  out  1  Wishbone strobe.
- ibus_we_o  out  1  Wishbone write enable; constant 0.
- ibus_sel_o  out  DATA_W/8  byte selects; constant all-ones.
- ibus_adr_o  out  ADDR_W  fetch address.
- ibus_ack_i  in  1  Wishbone acknowledge.
- ibus_dat_i  in  DATA_W  read data.
- inst_valid_o  out  1  queue head valid.
- inst_ready_i  in  1  ID stage accepts the head (low = stall).
- inst_o  out  DATA_W  head instruction.
- pc_o  out  ADDR_W  head PC.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  ADDR_W  restart address.

Behaviour:
- Reset values:
  - cyc = stb = 0
  - adr = RESET_PC
  - inst_valid_o = 0, inst_o = 0, pc_o = 0
  - fetch_pc = RESET_PC
  - queue count = 0, read/write pointers = 0
  - state = IDLE
- FSM states: IDLE, REQ, DRAIN.
- IDLE: cyc = stb = 0. Go to REQ at the next edge when count < DEPTH and redirect_i = 0.
- IDLE redirect: fetch_pc <= redirect_pc_i, queue flushed, stay IDLE for one cycle.
- REQ: cyc = stb = 1, adr = fetch_pc; held stable until ack.
- REQ, on ack without redirect:
  - Push {fetch_pc, ibus_dat_i}; fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - Stay in REQ (back-to-back, stb stays high) if post-push count < DEPTH, else go to IDLE.
  - Post-push count includes a same-cycle pop.
- REQ, redirect without ack: flush queue, fetch_pc <= redirect_pc_i, go to DRAIN. The in-flight transfer is never aborted.
- REQ, redirect with ack in the same cycle: ack data discarded (no push), queue flushed, fetch_pc <= redirect_pc_i, stay in REQ. adr = redirect_pc_i on the next cycle.
- DRAIN: cyc = stb = 1 with the old address. On ack, discard the data and go to REQ (or IDLE if count = DEPTH).
- DRAIN, second redirect: only updates fetch_pc (last redirect wins).
- Queue: circular, pointers of log2(DEPTH) bits wrapping naturally.
- Pop on inst_valid_o & inst_ready_i; push and pop may occur in the same cycle at any count.
- inst_valid_o = (count != 0); inst_o / pc_o show the head entry.
- Latency: data acked at edge N appears on inst_valid_o in the cycle after edge N, i.e. one cycle after the ack cycle.
- Redirect priority: redirect beats push and pop in the same cycle. The pop handshake is ignored. inst_valid_o is 0 in the cycle after a redirect.
- Overflow is impossible: a request is issued only when count < DEPTH.
- Reset mid-transaction: cyc/stb drop immediately (asynchronous). Any later ack for that transfer is ignored because state = IDLE.
- ibus_sel_o: all ones. ibus_we_o: 0.

Optional Feature:
- Macro IFU_BYPASS_EN.
- Defined: when count = 0 (after any flush) and an accepted ack occurs, inst_o / pc_o / inst_valid_o are driven combinationally from ibus_dat_i / fetch_pc in the ack cycle.
  - If inst_ready_i = 1 the entry is consumed without being pushed.
  - If inst_ready_i = 0 it is pushed as usual.
  - Zero-cycle fetch-to-ID latency on empty.
- Undefined: no combinational path from ibus_* to inst_*; latency is 1 cycle as above.

Test Plan:
- Reset release, slave acks on the second cycle of every stb, inst_ready_i = 1 → adr sequence BFC00000, BFC00004, BFC00008; pc_o/inst_o match in order; inst_valid_o rises one cycle after each ack.
- inst_ready_i = 0, zero-wait slave, DEPTH = 4 → exactly 4 acks, then stb = 0 with count = 4. Raise ready → 4 pops in order, then stb re-asserts with adr BFC00010.
- Redirect to 80000000 while stb is high and the ack is delayed 3 cycles → stb stays high on the old adr; ack data never appears; inst_valid_o = 0 throughout; next adr = 80000000.
- Redirect to 80001000 in the same cycle as an ack and a pop at count = 2 → no push, no pop, count = 0 next cycle; next adr = 80001000; first delivered pc_o = 80001000.
- Count = DEPTH-1 with simultaneous ack and pop → count stays DEPTH-1; stb remains high; FIFO order preserved across pointer wrap.
- Assert rst mid-REQ, slave acks one cycle later → cyc/stb = 0 asynchronously; late ack ignored; after release, first adr = BFC00000; with IFU_BYPASS_EN, inst_valid_o rises in that ack cycle.
